// File: rtl/logic_fn_sweeper_if.sv
// Bundle of signals between the sweeper, its host and the function under evaluation.
// Latency: none (wires only).
// Backpressure: none; start is level-sampled and ignored while a sweep is in progress.
// The slave modport is the sweeper's view. The master modport is the host and function
// side: it drives start, f_in and expected, and observes the results.
// Macro SWEEP_COMPARE_EN adds expected, err_count and mismatch.
interface logic_fn_sweeper_if;
   logic        start;
   logic        f_in;
   logic [3:0]  abcd;
   logic [15:0] truth;
   logic        busy;
   logic        done;
`ifdef SWEEP_COMPARE_EN
   logic [15:0] expected;
   logic [4:0]  err_count;
   logic        mismatch;

   modport slave  (input  start, f_in, expected,
                   output abcd, truth, busy, done, err_count, mismatch);
   modport master (output start, f_in, expected,
                   input  abcd, truth, busy, done, err_count, mismatch);
`else
   modport slave  (input  start, f_in,
                   output abcd, truth, busy, done);
   modport master (output start, f_in,
                   input  abcd, truth, busy, done);
`endif
endinterface

// File: rtl/logic_fn_sweeper.sv
// Sweeps a 4-input function over all 16 vectors and captures F into a truth table.
// Latency: 16*(SETTLE+1) busy cycles from the accept edge, then a one-cycle done pulse.
// Backpressure: start is accepted only in IDLE; a start seen in RUN or DONE is dropped.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   io_sw        : slave side of logic_fn_sweeper_if (start, f_in, abcd, truth, busy, done,
//                  plus expected/err_count/mismatch when SWEEP_COMPARE_EN is defined)
// Parameter SETTLE (0..15) sets the extra hold cycles per vector before F is sampled.
// Macro SWEEP_COMPARE_EN enables the compare stage against a table latched at accept.
module logic_fn_sweeper #(
   parameter int unsigned SETTLE = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   logic_fn_sweeper_if.slave    io_sw
);

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [3:0]  r_idx;
   logic [3:0]  r_settle_cnt;
   logic [3:0]  r_abcd;
   logic [15:0] r_truth;
   logic        r_busy;
   logic        r_done;

   logic        w_accept;
   logic        w_sample;
   logic        w_last;

   // ---------------- state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next state and strobes ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_sw.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // F is sampled once the hold count for the current vector has run out.
            if (r_settle_cnt == 4'd0) begin
               w_sample = 1'b1;
               if (r_idx == 4'd15) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------- sweep datapath ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx        <= 4'd0;
         r_settle_cnt <= 4'd0;
         r_abcd       <= 4'd0;
         r_truth      <= 16'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         // done is the cycle right after the last sample, so it follows w_last directly.
         r_done <= w_last;
         if (w_accept) begin
            r_busy       <= 1'b1;
            r_idx        <= 4'd0;
            r_abcd       <= 4'd0;
            r_settle_cnt <= SETTLE_C;
            r_truth      <= 16'd0;
         end else if (r_state == S_RUN) begin
            if (!w_sample) begin
               r_settle_cnt <= r_settle_cnt - 4'd1;
            end else begin
               r_truth[r_idx] <= io_sw.f_in;
               if (w_last) begin
                  r_busy <= 1'b0;
               end else begin
                  // abcd moves together with idx so the function sees a clean registered step.
                  r_idx        <= r_idx + 4'd1;
                  r_abcd       <= r_idx + 4'd1;
                  r_settle_cnt <= SETTLE_C;
               end
            end
         end
      end
   end

   assign io_sw.abcd  = r_abcd;
   assign io_sw.truth = r_truth;
   assign io_sw.busy  = r_busy;
   assign io_sw.done  = r_done;

`ifdef SWEEP_COMPARE_EN
   // ---------------- compare stage ----------------
   logic [15:0] r_expected;
   logic [4:0]  r_err_count;
   logic        r_mismatch;
   logic [4:0]  w_err_nxt;

   assign w_err_nxt = r_err_count + {4'd0, (io_sw.f_in != r_expected[r_idx])};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_expected  <= 16'd0;
         r_err_count <= 5'd0;
         r_mismatch  <= 1'b0;
      end else if (w_accept) begin
         r_expected  <= io_sw.expected;
         r_err_count <= 5'd0;
         r_mismatch  <= 1'b0;
      end else if (w_sample) begin
         // mismatch tracks the updated count so both are final on the done cycle.
         r_err_count <= w_err_nxt;
         r_mismatch  <= (w_err_nxt != 5'd0);
      end
   end

   assign io_sw.err_count = r_err_count;
   assign io_sw.mismatch  = r_mismatch;
`endif

endmodule

// File: tb/tb_logic_fn_sweeper.sv
module tb_logic_fn_sweeper;

   localparam int MAXC = 80;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic_fn_sweeper_if if0 ();
   logic_fn_sweeper_if if1 ();

   logic_fn_sweeper #(.SETTLE(0)) u0 (.i_clk(clk), .i_rst(rst), .io_sw(if0));
   logic_fn_sweeper #(.SETTLE(1)) u1 (.i_clk(clk), .i_rst(rst), .io_sw(if1));

   // The function under evaluation, held as its truth table.
   logic [15:0] fn_tab = 16'd0;
   assign if0.f_in = fn_tab[if0.abcd];
   assign if1.f_in = fn_tab[if1.abcd];

   int n_vec = 0;
   int n_err = 0;
   int sel   = 0;

   logic        m_busy, m_done;
   logic [3:0]  m_abcd;
   logic [15:0] m_truth;
   logic [4:0]  m_err;
   logic        m_mm;

   always_comb begin
      m_err = 5'd0;
      m_mm  = 1'b0;
      if (sel == 0) begin
         m_busy = if0.busy; m_done = if0.done; m_abcd = if0.abcd; m_truth = if0.truth;
`ifdef SWEEP_COMPARE_EN
         m_err = if0.err_count; m_mm = if0.mismatch;
`endif
      end else begin
         m_busy = if1.busy; m_done = if1.done; m_abcd = if1.abcd; m_truth = if1.truth;
`ifdef SWEEP_COMPARE_EN
         m_err = if1.err_count; m_mm = if1.mismatch;
`endif
      end
   end

   // Observations of the most recent sweep (k = cycles after the accept edge).
   logic        obs_busy [MAXC];
   logic        obs_done [MAXC];
   logic [3:0]  obs_abcd [MAXC];
   int          obs_len;
   int          done_at;
   logic [15:0] truth0, truth_end;
   logic [4:0]  err0, err_end;
   logic        mm_end;

   // Reference: F = (A ^ B) & (C | ~D) evaluated for every vector.
   function automatic logic [15:0] spec_f_table();
      logic [15:0] t;
      t = 16'd0;
      for (int i = 0; i < 16; i++) begin
         int a, b, c, d;
         a = (i >> 3) & 1; b = (i >> 2) & 1; c = (i >> 1) & 1; d = i & 1;
         t[i] = ((a ^ b) & (c | (1 - d))) != 0;
      end
      return t;
   endfunction

   function automatic int popcount16(input logic [15:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic set_start(input int s, input logic v);
      if (s == 0) if0.start = v; else if1.start = v;
   endtask

   task automatic set_exp(input int s, input logic [15:0] v);
`ifdef SWEEP_COMPARE_EN
      if (s == 0) if0.expected = v; else if1.expected = v;
`endif
   endtask

   // Stimulus only: one start pulse on DUT s, then record outputs until one cycle past done.
   task automatic do_sweep(input int s, input logic [15:0] exp_v,
                           input int chg_at, input logic [15:0] chg_v);
      sel = s;
      for (int k = 0; k < MAXC; k++) begin
         obs_busy[k] = 1'bx; obs_done[k] = 1'bx; obs_abcd[k] = 4'bx;
      end
      done_at = -1; obs_len = 0; truth_end = 16'bx; err_end = 5'bx; mm_end = 1'bx;
      @(negedge clk);
      set_start(s, 1'b1);
      set_exp(s, exp_v);
      @(posedge clk); #1;
      set_start(s, 1'b0);
      for (int k = 0; k < MAXC; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         obs_busy[k] = m_busy; obs_done[k] = m_done; obs_abcd[k] = m_abcd;
         if (k == 0) begin truth0 = m_truth; err0 = m_err; end
         if (k == chg_at) set_exp(s, chg_v);
         obs_len = k + 1;
         if (m_done === 1'b1 && done_at < 0) begin
            done_at = k; truth_end = m_truth; err_end = m_err; mm_end = m_mm;
         end
         if (done_at >= 0 && k == done_at + 1) break;
      end
   endtask

   task automatic test_reset;
      // power-on state of both DUTs
      sel = 0; #1;
      n_vec++;
      if ({m_busy, m_done, m_abcd, m_truth, m_err, m_mm} !== 27'd0) begin
         n_err++; $display("FAIL reset_u0 got busy=%b done=%b abcd=%h truth=%h err=%0d mm=%b want all 0",
                           m_busy, m_done, m_abcd, m_truth, m_err, m_mm);
      end
      sel = 1; #1;
      n_vec++;
      if ({m_busy, m_done, m_abcd, m_truth, m_err, m_mm} !== 27'd0) begin
         n_err++; $display("FAIL reset_u1 got busy=%b done=%b abcd=%h truth=%h err=%0d mm=%b want all 0",
                           m_busy, m_done, m_abcd, m_truth, m_err, m_mm);
      end
      // abort mid-run with start held high alongside reset
      fn_tab = 16'hFFFF;
      @(negedge clk); if1.start = 1'b1;
      @(posedge clk); #1; if1.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_vec++;
      if (m_busy !== 1'b1 || m_truth === 16'd0) begin
         n_err++; $display("FAIL reset_midrun_setup got busy=%b truth=%h want busy=1 truth!=0", m_busy, m_truth);
      end
      @(negedge clk); rst = 1'b1; if1.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({m_busy, m_done, m_abcd, m_truth, m_err, m_mm} !== 27'd0) begin
         n_err++; $display("FAIL reset_abort got busy=%b done=%b abcd=%h truth=%h err=%0d want all 0",
                           m_busy, m_done, m_abcd, m_truth, m_err);
      end
      @(negedge clk); rst = 1'b0; if1.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (m_busy !== 1'b0) begin
         n_err++; $display("FAIL reset_stays_idle got busy=%b want 0", m_busy);
      end
      do_sweep(1, 16'hFFFF, -1, 16'd0);
      n_vec++;
      if (done_at !== 32 || truth_end !== 16'hFFFF) begin
         n_err++; $display("FAIL reset_resweep got done_at=%0d truth=%h want 32 FFFF", done_at, truth_end);
      end
   endtask

   task automatic test_settle1_sweep;
      logic [15:0] want;
      for (int t = 0; t < 5; t++) begin
         fn_tab = (t == 0) ? spec_f_table() : 16'($urandom);
         want = fn_tab;
         do_sweep(1, 16'd0, -1, 16'd0);
         for (int k = 0; k < 32; k++) begin
            n_vec++;
            if (obs_abcd[k] !== 4'(k / 2) || obs_busy[k] !== 1'b1) begin
               n_err++; $display("FAIL s1_trace t=%0d k=%0d got abcd=%h busy=%b want abcd=%h busy=1",
                                 t, k, obs_abcd[k], obs_busy[k], 4'(k / 2));
            end
         end
         n_vec++;
         if (done_at !== 32 || obs_done[33] !== 1'b0 || obs_busy[33] !== 1'b0) begin
            n_err++; $display("FAIL s1_done t=%0d got done_at=%0d after=%b/%b want 32 and 0/0",
                              t, done_at, obs_done[33], obs_busy[33]);
         end
         n_vec++;
         if (truth_end !== want || truth0 !== 16'd0) begin
            n_err++; $display("FAIL s1_truth t=%0d got %h (at accept %h) want %h (at accept 0000)",
                              t, truth_end, truth0, want);
         end
         if (t == 0) begin
            n_vec++;
            if (truth_end !== 16'h0DD0) begin
               n_err++; $display("FAIL s1_specF got %h want 0DD0", truth_end);
            end
         end
      end
   endtask

   task automatic test_settle0_const;
      int nb;
      fn_tab = 16'hFFFF;
      do_sweep(0, 16'd0, -1, 16'd0);
      nb = 0;
      for (int k = 0; k < obs_len; k++) if (obs_busy[k] === 1'b1) nb++;
      n_vec++;
      if (nb != 16 || done_at !== 16) begin
         n_err++; $display("FAIL s0_busy got busy_cycles=%0d done_at=%0d want 16 16", nb, done_at);
      end
      n_vec++;
      if (truth_end !== 16'hFFFF) begin
         n_err++; $display("FAIL s0_ones got %h want FFFF", truth_end);
      end
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (m_truth !== 16'hFFFF || m_done !== 1'b0) begin
         n_err++; $display("FAIL s0_hold got truth=%h done=%b want FFFF 0", m_truth, m_done);
      end
      fn_tab = 16'h0000;
      do_sweep(0, 16'd0, -1, 16'd0);
      n_vec++;
      if (truth0 !== 16'd0 || truth_end !== 16'h0000 || done_at !== 16) begin
         n_err++; $display("FAIL s0_zeros got accept=%h end=%h done_at=%0d want 0000 0000 16",
                           truth0, truth_end, done_at);
      end
   endtask

   task automatic test_back_to_back;
      int per;
      per = 18;
      fn_tab = 16'($urandom);
      sel = 0;
      @(negedge clk); if0.start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3 * per; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         n_vec++;
         if (m_busy !== ((k % per) < 16) || m_done !== ((k % per) == 16)) begin
            n_err++; $display("FAIL b2b k=%0d got busy=%b done=%b want busy=%b done=%b",
                              k, m_busy, m_done, (k % per) < 16, (k % per) == 16);
         end
         if ((k % per) == 16) begin
            n_vec++;
            if (m_truth !== fn_tab) begin
               n_err++; $display("FAIL b2b_truth k=%0d got %h want %h", k, m_truth, fn_tab);
            end
         end
      end
      if0.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (m_busy !== 1'b0) begin
         n_err++; $display("FAIL b2b_stop got busy=%b want 0", m_busy);
      end
   endtask

`ifdef SWEEP_COMPARE_EN
   task automatic test_compare;
      logic [15:0] exps [6];
      int want;
      for (int t = 0; t < 6; t++) begin
         fn_tab = (t < 3) ? spec_f_table() : 16'($urandom);
         exps[t] = (t == 0) ? 16'h0DD0 : (t == 1) ? 16'h0DD1 : (t == 2) ? ~16'h0DD0 : 16'($urandom);
         want = popcount16(fn_tab ^ exps[t]);
         do_sweep(t % 2, exps[t], -1, 16'd0);
         n_vec++;
         if (err0 !== 5'd0 || err_end !== 5'(want) || mm_end !== (want != 0)) begin
            n_err++; $display("FAIL cmp t=%0d got err=%0d (accept %0d) mm=%b want err=%0d mm=%b",
                              t, err_end, err0, mm_end, want, want != 0);
         end
      end
   endtask

   task automatic test_expected_latch;
      logic [15:0] e;
      int want;
      fn_tab = 16'($urandom);
      e = 16'($urandom);
      want = popcount16(fn_tab ^ e);
      do_sweep(1, e, 9, ~e);
      n_vec++;
      if (err_end !== 5'(want) || mm_end !== (want != 0)) begin
         n_err++; $display("FAIL cmp_latch got err=%0d mm=%b want err=%0d mm=%b",
                           err_end, mm_end, want, want != 0);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if0.start = 1'b0; if1.start = 1'b0;
      set_exp(0, 16'd0); set_exp(1, 16'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      test_reset();
      test_settle1_sweep();
      test_settle0_const();
      test_back_to_back();
`ifdef SWEEP_COMPARE_EN
      test_compare();
      test_expected_latch();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/logic_fn_sweeper.md
# logic_fn_sweeper

Sequential controller that drives a 4-input combinational logic function (A, B, C, D → F) through all 16 input vectors and captures the response into a 16-bit truth-table register. It sits between a test/control host and the function under evaluation: it owns the function's inputs, samples its output after a configurable settle delay, and reports completion with a start/busy/done handshake. An optional compare stage checks the captured table against an expected table.

## Interface
- SETTLE, default 1: number of extra cycles each vector is held before F is sampled; legal range 0..15.

- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sweep; accepted only in IDLE
- f_in  in  1  output F of the evaluated function
- abcd  out  4  function inputs, registered; bit3=A, bit2=B, bit1=C, bit0=D
- truth  out  16  captured table; truth[i] = F for abcd == i
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- expected  in  16  expected table (only with SWEEP_COMPARE_EN)
- err_count  out  5  number of mismatching vectors, 0..16 (only with SWEEP_COMPARE_EN)
- mismatch  out  1  err_count != 0 (only with SWEEP_COMPARE_EN)

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE; abcd=0, truth=0, busy=0, done=0, err_count=0, mismatch=0; internal idx=0, settle_cnt=0.
- IDLE: on start=1, go to RUN: busy=1, idx=0, abcd=0, settle_cnt=SETTLE, truth cleared to 0 (and err_count cleared, expected latched when the macro is enabled).
- RUN, each edge:
  - settle_cnt != 0: decrement.
  - settle_cnt == 0: truth[idx] <= f_in. If idx == 15, go to DONE. Otherwise idx <= idx+1, abcd <= idx+1, settle_cnt <= SETTLE.
- DONE: exactly one cycle; done=1, busy=0; then IDLE. truth (and err_count/mismatch) hold until the next accepted start.
- start in RUN or DONE is ignored; it is not queued.
- idx is 4 bits and never wraps: the last sample is idx=15.
- rst asserted mid-sweep aborts immediately: all outputs return to reset values on the next edge and the partial table is discarded.
- rst and start high together: reset wins.

## Timing
- Accept edge E0 (start=1 in IDLE). Vector i is driven on abcd from edge E0+i·(SETTLE+1). f_in is sampled at edge E0+(i+1)·(SETTLE+1).
- busy is high for 16·(SETTLE+1) cycles. done is high in the following cycle. The earliest next accept is the cycle after done.
- SETTLE=0: 16 busy cycles, one sample per cycle. SETTLE=1: 32 busy cycles.
- abcd is glitch-free (registered) and stable for SETTLE+1 cycles per vector. f_in must settle within SETTLE+1 cycles of clk.

## Configuration
- SWEEP_COMPARE_EN defined:
  - expected is latched at accept.
  - On each sample, err_count increments when f_in != expected[idx] (saturating is not needed; max 16 fits in 5 bits).
  - mismatch = (err_count != 0), registered. Both are valid when done pulses and hold afterwards.
- SWEEP_COMPARE_EN undefined: the expected, err_count and mismatch ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst for 2 cycles mid-RUN → next cycle busy=0, done=0, abcd=0, truth=0, state IDLE; a subsequent start yields a complete sweep.
- Sweep of F = (A^B)&(C|~D), SETTLE=1, start pulse → abcd steps 0..15 every 2 cycles; busy high 32 cycles; done one cycle; truth=0x0DD0.
- SETTLE=0, f_in tied to 1 → busy exactly 16 cycles; truth=0xFFFF. Then f_in tied to 0 with a new start → truth=0x0000 (cleared and re-captured).
- start held high continuously through RUN and DONE → exactly one sweep per IDLE visit; a new sweep begins the cycle after done, never overlapping.
- SWEEP_COMPARE_EN, expected=0x0DD0, F as above → done with err_count=0, mismatch=0. With expected=0x0DD1 → err_count=1, mismatch=1. With expected=~0x0DD0 → err_count=16.
- SWEEP_COMPARE_EN, change expected mid-sweep → result is unaffected (the value latched at accept is used).
